// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - fetch address register and return-address stack feeding prefetch
// Optional ISP_GUARD_EN: drop overflowing pushes, zero the address on empty pops, raise sticky err.
module pc_stack #(
    parameter int MINSTW = 8,
    parameter int SDEPTH = 8,
    localparam int SPW = $clog2(SDEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_l,
    input  logic [MINSTW-1:0] instr_addr,
    input  logic              isp_push,
    input  logic              isp_pop,
    input  logic              itr,
    output logic [MINSTW-1:0] addr,
    output logic [SPW-1:0]    sp,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam int IW = $clog2(SDEPTH);

    logic [MINSTW-1:0] stk [SDEPTH];
    logic [MINSTW-1:0] addr_nxt;
    logic [MINSTW-1:0] wr_data;
    logic [MINSTW-1:0] top;
    logic [SPW-1:0]    sp_nxt;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     top_idx;
    logic              wr_en;
    logic              err_nxt;
    logic              push_req;

    assign empty   = (sp == '0);
    assign full    = (sp == SPW'(SDEPTH));
    // Low index bits wrap naturally, so an empty stack reads the last slot.
    assign wr_idx  = sp[IW-1:0];
    assign top_idx = sp[IW-1:0] - IW'(1);
    assign top     = stk[top_idx];

    always_comb begin
        addr_nxt = addr + MINSTW'(1);
        sp_nxt   = sp;
        err_nxt  = err;
        wr_en    = 1'b0;
        wr_data  = addr + MINSTW'(1);
        push_req = 1'b0;

        if (itr) begin
            // Resume at the instruction not fetched this cycle.
            push_req = 1'b1;
            wr_data  = addr;
            addr_nxt = instr_addr + MINSTW'(1);
        end else if (isp_pop) begin
`ifdef ISP_GUARD_EN
            if (empty) begin
                addr_nxt = '0;
                err_nxt  = 1'b1;
            end else begin
                addr_nxt = top;
                sp_nxt   = sp - SPW'(1);
            end
`else
            addr_nxt = top;
            if (!empty)
                sp_nxt = sp - SPW'(1);
`endif
        end else if (isp_push) begin
            push_req = 1'b1;
            addr_nxt = instr_addr + MINSTW'(1);
        end else if (pc_l) begin
            addr_nxt = instr_addr + MINSTW'(1);
        end

        if (push_req) begin
`ifdef ISP_GUARD_EN
            if (full) begin
                err_nxt = 1'b1;
            end else begin
                wr_en  = 1'b1;
                sp_nxt = sp + SPW'(1);
            end
`else
            // Circular overwrite of the oldest entry once the count saturates.
            wr_en = 1'b1;
            if (!full)
                sp_nxt = sp + SPW'(1);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            sp   <= '0;
            err  <= 1'b0;
        end else begin
            addr <= addr_nxt;
            sp   <= sp_nxt;
            err  <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            stk[wr_idx] <= wr_data;
    end

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - directed self-checking bench for pc_stack
module tb_pc_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pc_l = 1'b0;
    logic [7:0] instr_addr = 8'h00;
    logic       isp_push = 1'b0;
    logic       isp_pop = 1'b0;
    logic       itr = 1'b0;
    logic [7:0] addr;
    logic [3:0] sp;
    logic       empty;
    logic       full;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ISP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    pc_stack #(.MINSTW(8), .SDEPTH(8)) dut (
        .clk(clk), .rst(rst), .pc_l(pc_l), .instr_addr(instr_addr),
        .isp_push(isp_push), .isp_pop(isp_pop), .itr(itr),
        .addr(addr), .sp(sp), .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic pl, input logic pu, input logic po, input logic it, input logic [7:0] ia);
        pc_l = pl; isp_push = pu; isp_pop = po; itr = it; instr_addr = ia;
        @(posedge clk); #1;
        pc_l = 1'b0; isp_push = 1'b0; isp_pop = 1'b0; itr = 1'b0; instr_addr = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", addr); end
        n_cmp++; if (sp !== 4'd0) begin n_bad++; $display("FAIL reset_sp: got %0d want 0", sp); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (addr !== 8'h00) begin n_bad++; $display("FAIL reset_hold: got %h want 00", addr); end
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 0, 8'h00);
            n_cmp++; if (addr !== 8'(i)) begin n_bad++; $display("FAIL seq_addr%0d: got %h want %h", i, addr, 8'(i)); end
        end
        n_cmp++; if (empty !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL seq_flags: got empty=%b err=%b want 1/0", empty, err); end
    endtask

    task automatic test_jump();
        do_reset();
        cyc(0, 0, 0, 0, 8'h00); cyc(0, 0, 0, 0, 8'h00); cyc(0, 0, 0, 0, 8'h00);
        n_cmp++; if (addr !== 8'h03) begin n_bad++; $display("FAIL jump_pre: got %h want 03", addr); end
        cyc(1, 0, 0, 0, 8'h40);
        n_cmp++; if (addr !== 8'h41) begin n_bad++; $display("FAIL jump_addr: got %h want 41", addr); end
        n_cmp++; if (sp !== 4'd0) begin n_bad++; $display("FAIL jump_sp: got %0d want 0", sp); end
    endtask

    task automatic test_call_return();
        do_reset();
        cyc(1, 0, 0, 0, 8'h0F);
        cyc(1, 1, 0, 0, 8'h80);
        n_cmp++; if (addr !== 8'h81) begin n_bad++; $display("FAIL call_addr: got %h want 81", addr); end
        n_cmp++; if (sp !== 4'd1 || empty !== 1'b0) begin n_bad++; $display("FAIL call_sp: got sp=%0d empty=%b want 1/0", sp, empty); end
        cyc(0, 0, 0, 0, 8'h00); cyc(0, 0, 0, 0, 8'h00);
        // push alongside pop is ignored
        cyc(1, 1, 1, 0, 8'h33);
        n_cmp++; if (addr !== 8'h11) begin n_bad++; $display("FAIL ret_addr: got %h want 11", addr); end
        n_cmp++; if (sp !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL ret_sp: got sp=%0d empty=%b want 0/1", sp, empty); end
    endtask

    task automatic test_itr_priority();
        do_reset();
        cyc(1, 0, 0, 0, 8'h21);
        cyc(1, 1, 1, 1, 8'h00);
        n_cmp++; if (addr !== 8'h01) begin n_bad++; $display("FAIL itr_addr: got %h want 01", addr); end
        n_cmp++; if (sp !== 4'd1) begin n_bad++; $display("FAIL itr_sp: got %0d want 1", sp); end
        cyc(0, 0, 1, 0, 8'h00);
        n_cmp++; if (addr !== 8'h22) begin n_bad++; $display("FAIL itr_ret: got %h want 22", addr); end
        n_cmp++; if (sp !== 4'd0) begin n_bad++; $display("FAIL itr_ret_sp: got %0d want 0", sp); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_pop [9];
        logic [3:0] exp_sp;
        if (GUARD) exp_pop = '{8'h58, 8'h57, 8'h56, 8'h55, 8'h54, 8'h53, 8'h52, 8'h51, 8'h00};
        else       exp_pop = '{8'h58, 8'h57, 8'h56, 8'h55, 8'h54, 8'h53, 8'h52, 8'h59, 8'h58};
        do_reset();
        cyc(1, 0, 0, 0, 8'h4F);
        for (int k = 0; k < 9; k++) begin
            cyc(1, 1, 0, 0, 8'(8'h50 + k));
            n_cmp++; if (addr !== 8'(8'h51 + k)) begin n_bad++; $display("FAIL push%0d_addr: got %h want %h", k, addr, 8'(8'h51 + k)); end
            if (k == 6) begin
                n_cmp++; if (full !== 1'b0 || sp !== 4'd7) begin n_bad++; $display("FAIL push7_full: got full=%b sp=%0d want 0/7", full, sp); end
            end
            if (k == 7) begin
                n_cmp++; if (full !== 1'b1 || sp !== 4'd8) begin n_bad++; $display("FAIL push8_full: got full=%b sp=%0d want 1/8", full, sp); end
                n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL push8_err: got %b want 0", err); end
            end
        end
        n_cmp++; if (sp !== 4'd8 || full !== 1'b1) begin n_bad++; $display("FAIL push9_sp: got sp=%0d full=%b want 8/1", sp, full); end
        n_cmp++; if (err !== GUARD) begin n_bad++; $display("FAIL push9_err: got %b want %b", err, GUARD); end
        for (int j = 0; j < 9; j++) begin
            cyc(0, 0, 1, 0, 8'h00);
            exp_sp = (j < 8) ? 4'(7 - j) : 4'd0;
            n_cmp++; if (addr !== exp_pop[j]) begin n_bad++; $display("FAIL pop%0d_addr: got %h want %h", j, addr, exp_pop[j]); end
            n_cmp++; if (sp !== exp_sp) begin n_bad++; $display("FAIL pop%0d_sp: got %0d want %0d", j, sp, exp_sp); end
        end
        n_cmp++; if (err !== GUARD || empty !== 1'b1) begin n_bad++; $display("FAIL pop_end_flags: got err=%b empty=%b want %b/1", err, empty, GUARD); end
    endtask

    task automatic test_wrap_async();
        do_reset();
        cyc(1, 0, 0, 0, 8'hFE);
        n_cmp++; if (addr !== 8'hFF) begin n_bad++; $display("FAIL wrap_pre: got %h want ff", addr); end
        cyc(0, 0, 0, 0, 8'h00);
        n_cmp++; if (addr !== 8'h00) begin n_bad++; $display("FAIL wrap_addr: got %h want 00", addr); end
        cyc(1, 0, 0, 0, 8'hFF);
        n_cmp++; if (addr !== 8'h00) begin n_bad++; $display("FAIL wrap_load: got %h want 00", addr); end
        cyc(1, 1, 0, 0, 8'h10); cyc(1, 1, 0, 0, 8'h20); cyc(1, 1, 0, 0, 8'h30);
        n_cmp++; if (sp !== 4'd3 || addr !== 8'h31) begin n_bad++; $display("FAIL async_pre: got sp=%0d addr=%h want 3/31", sp, addr); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (sp !== 4'd0 || addr !== 8'h00 || empty !== 1'b1) begin n_bad++; $display("FAIL async_rst: got sp=%0d addr=%h empty=%b want 0/00/1", sp, addr, empty); end
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0, 8'h00);
        n_cmp++; if (addr !== 8'h01) begin n_bad++; $display("FAIL post_rst: got %h want 01", addr); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_call_return();
        test_itr_priority();
        test_overflow();
        test_wrap_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
